stl_rr_arb_slice: RTL



---
 rtl/stl_arb_pkg.sv | 21 ++
 rtl/stl_rr_arb_slice_if.sv | 26 ++
 rtl/stl_rr_arb_slice_find_one.sv | 36 +++
 rtl/stl_rr_arb_slice.sv | 82 ++++++++
 4 files changed

// File: rtl/stl_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package stl_arb_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int unsigned PTR_MAX_W = 16;

  // Pointer advance; wrap falls out of the mask because REQ_N is a power of two.
  function automatic logic [PTR_MAX_W-1:0] ptr_inc(
    input logic [PTR_MAX_W-1:0] p,
    input int unsigned          idx_w
  );
    logic [PTR_MAX_W-1:0] mask;
    mask = (PTR_MAX_W'(1) << idx_w) - PTR_MAX_W'(1);
    return (p + PTR_MAX_W'(1)) & mask;
  endfunction

endpackage

// File: rtl/stl_rr_arb_slice_if.sv
// Requester-array / consumer handshake bundle for stl_rr_arb_slice.
interface stl_rr_arb_slice_if #(
  parameter int unsigned REQ_N  = 16,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned IDX_W = $clog2(REQ_N);

  logic [REQ_N-1:0]             req_i;
  logic [REQ_N-1:0][DATA_W-1:0] req_data_i;
  logic [REQ_N-1:0]             gnt_o;
  logic                         out_vld_o;
  logic                         out_rdy_i;
  logic [DATA_W-1:0]            out_data_o;
  logic [IDX_W-1:0]             out_idx_o;

  modport slave (
    input  req_i, req_data_i, out_rdy_i,
    output gnt_o, out_vld_o, out_data_o, out_idx_o
  );

  modport master (
    output req_i, req_data_i, out_rdy_i,
    input  gnt_o, out_vld_o, out_data_o, out_idx_o
  );

endinterface

// File: rtl/stl_rr_arb_slice_find_one.sv
// Rotating find-first-one: first set request scanning upward from start_pos_i with wrap.
module stl_rr_arb_slice_find_one #(
  parameter  int unsigned REQ_N  = 16,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned IDX_W  = $clog2(REQ_N)
) (
  input  logic [REQ_N-1:0]             req_i,
  input  logic [REQ_N-1:0][DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]             start_pos_i,
  output logic                         found_o,
  output logic [IDX_W-1:0]             fone_pos_o,
  output logic [DATA_W-1:0]            data_sel_o
);

  logic             hit;
  logic [IDX_W-1:0] pos;
  logic [IDX_W-1:0] idx;

  always_comb begin
    hit = 1'b0;
    pos = '0;
    idx = '0;
    for (int unsigned k = 0; k < REQ_N; k++) begin
      idx = start_pos_i + IDX_W'(k);
      if (!hit && req_i[idx]) begin
        hit = 1'b1;
        pos = idx;
      end
    end
  end

  assign found_o    = hit;
  assign fone_pos_o = pos;
  assign data_sel_o = data_i[pos];

endmodule

// File: rtl/stl_rr_arb_slice.sv
// Round-robin arbiter feeding a one-entry valid/ready output slice.
// Optional fixed-priority override: define STL_RR_ARB_FIXPRI_EN to add prio_fix_i.
module stl_rr_arb_slice
  import stl_arb_pkg::*;
#(
  parameter int unsigned REQ_N  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic clk,
  input  logic rst_n,
`ifdef STL_RR_ARB_FIXPRI_EN
  input  logic prio_fix_i,
`endif
  stl_rr_arb_slice_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(REQ_N);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  start_pos;
  logic [IDX_W-1:0]  sel;
  logic [DATA_W-1:0] data_sel;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_q;
  logic              found;
  logic              fix;
  logic              take;

`ifdef STL_RR_ARB_FIXPRI_EN
  assign fix = prio_fix_i;
`else
  assign fix = 1'b0;
`endif

  assign start_pos = fix ? '0 : ptr;

  stl_rr_arb_slice_find_one #(
    .REQ_N  (REQ_N),
    .DATA_W (DATA_W)
  ) u_find_one (
    .req_i       (bus.req_i),
    .data_i      (bus.req_data_i),
    .start_pos_i (start_pos),
    .found_o     (found),
    .fone_pos_o  (sel),
    .data_sel_o  (data_sel)
  );

  // rst_n gates take so no grant escapes while the slice is held in reset.
  assign take = rst_n && found && ((state == ST_EMPTY) || bus.out_rdy_i);

  always_comb begin
    bus.gnt_o = '0;
    if (take) begin
      bus.gnt_o = REQ_N'(1) << sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      ptr    <= '0;
      data_q <= '0;
      idx_q  <= '0;
    end else if (take) begin
      state  <= ST_FULL;
      data_q <= data_sel;
      idx_q  <= sel;
      if (!fix) begin
        ptr <= IDX_W'(ptr_inc(PTR_MAX_W'(sel), IDX_W));
      end
    end else if ((state == ST_FULL) && bus.out_rdy_i) begin
      state <= ST_EMPTY;
    end
  end

  assign bus.out_vld_o  = (state == ST_FULL);
  assign bus.out_data_o = data_q;
  assign bus.out_idx_o  = idx_q;

endmodule
